fifo_dc_wm_cntl: RTL and testbench

FIFO_DC_WM_CNTL -- requirements
Module: fifo_dc_wm_cntl

---
 rtl/fifo_dc_pkg.sv | 40 ++++
 rtl/dfafn_gray2bin.sv | 20 ++
 rtl/fifo_dc_wm_cntl.sv | 158 +++++++++++++++
 tb/tb_fifo_dc_wm_cntl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_dc_pkg.sv
// fifo_dc_pkg: shared widths, level arithmetic and parameter-legality helpers
// for the dual-clock watermark FIFO controller.
`default_nettype none

package fifo_dc_pkg;

   localparam int MIN_ENTRIES     = 4;
   localparam int MAX_ENTRIES     = 1024;
   localparam int MIN_SYNC_STAGES = 2;
   localparam int MAX_SYNC_STAGES = 4;
   // Wide enough for the largest pointer (11 bits) plus one spare bit.
   localparam int LVL_W_MAX       = 12;

   function automatic int ptr_width(input int entries);
      return $clog2(entries) + 1;
   endfunction

   // Occupancy between two binary pointers, modulo 2^width.
   function automatic logic [LVL_W_MAX-1:0] level_diff(
      input logic [LVL_W_MAX-1:0] ahead,
      input logic [LVL_W_MAX-1:0] behind,
      input int                   width
   );
      logic [LVL_W_MAX-1:0] mask;
      mask = (LVL_W_MAX'(1) << width) - LVL_W_MAX'(1);
      return (ahead - behind) & mask;
   endfunction

   function automatic bit params_ok(input int entries, input int sync_stages,
                                    input int af_level, input int ae_level);
      return (entries >= MIN_ENTRIES) && (entries <= MAX_ENTRIES)
          && ((entries & (entries - 1)) == 0)
          && (sync_stages >= MIN_SYNC_STAGES) && (sync_stages <= MAX_SYNC_STAGES)
          && (af_level >= 1) && (af_level <= entries - 1)
          && (ae_level >= 1) && (ae_level <= entries - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dfafn_gray2bin.sv
// dfafn_gray2bin: combinational Gray-to-binary converter.
`default_nettype none

module dfafn_gray2bin #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   always_comb begin
      bin = '0;
      for (int i = 0; i < W; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_dc_wm_cntl.sv
// fifo_dc_wm_cntl: dual-clock FIFO pointer/flag controller with watermarks.
// Define FIFO_DC_WM_ERR_EN to add sticky overflow_ff / underflow_ff outputs.
`default_nettype none

module fifo_dc_wm_cntl
   import fifo_dc_pkg::*;
#(
   parameter int NUM_ENTRIES = 16,
   parameter int SYNC_STAGES = 2,
   parameter int AF_LEVEL    = NUM_ENTRIES - 2,
   parameter int AE_LEVEL    = 2,
   localparam int PW         = ptr_width(NUM_ENTRIES),
   localparam int AW         = PW - 1
) (
   input  logic          clk_pop,
   input  logic          clk_push,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   output logic          we,
   output logic          re,
   output logic [AW-1:0] waddr_ff,
   output logic [AW-1:0] raddr_ff,
   output logic          full_ff,
   output logic          almost_full_ff,
   output logic          empty_ff,
   output logic          almost_empty_ff,
   output logic [AW:0]   wr_level,
`ifdef FIFO_DC_WM_ERR_EN
   output logic [AW:0]   rd_level,
   output logic          overflow_ff,
   output logic          underflow_ff
`else
   output logic [AW:0]   rd_level
`endif
);

   localparam logic [PW-1:0] FULL_LVL = PW'(NUM_ENTRIES);
   localparam logic [PW-1:0] AF_LVL   = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_LVL   = PW'(AE_LEVEL);

   if (!params_ok(NUM_ENTRIES, SYNC_STAGES, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
      $error("fifo_dc_wm_cntl: illegal parameter combination");
   end

   // ---------------- push domain ----------------
   logic [1:0]    push_rst_sync;
   logic          push_rst_n;
   logic [PW-1:0] wptr_bin, wptr_gray, wptr_next, rptr_sync_bin, wr_level_next;
   logic [PW-1:0] rptr_gray;
   logic [PW-1:0] rptr_sync [SYNC_STAGES];

   // Reset asserts asynchronously, releases after two clk_push edges.
   always_ff @(posedge clk_push or negedge rst_n) begin
      if (!rst_n) push_rst_sync <= 2'b00;
      else        push_rst_sync <= {push_rst_sync[0], 1'b1};
   end
   assign push_rst_n = push_rst_sync[1];

   assign we            = push & ~full_ff;
   assign wptr_next     = wptr_bin + PW'(we);
   assign wr_level_next = PW'(level_diff(LVL_W_MAX'(wptr_next), LVL_W_MAX'(rptr_sync_bin), PW));

   always_ff @(posedge clk_push or negedge push_rst_n) begin
      if (!push_rst_n) begin
         wptr_bin       <= '0;
         wptr_gray      <= '0;
         wr_level       <= '0;
         full_ff        <= 1'b1;
         almost_full_ff <= 1'b1;
      end else begin
         wptr_bin       <= wptr_next;
         wptr_gray      <= wptr_next ^ (wptr_next >> 1);
         wr_level       <= wr_level_next;
         full_ff        <= (wr_level_next == FULL_LVL);
         almost_full_ff <= (wr_level_next >= AF_LVL);
      end
   end

   always_ff @(posedge clk_push or negedge push_rst_n) begin
      if (!push_rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) rptr_sync[i] <= '0;
      end else begin
         rptr_sync[0] <= rptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) rptr_sync[i] <= rptr_sync[i-1];
      end
   end

   dfafn_gray2bin #(.W(PW)) u_rptr_g2b (
      .gray (rptr_sync[SYNC_STAGES-1]),
      .bin  (rptr_sync_bin)
   );

   assign waddr_ff = wptr_bin[AW-1:0];

   // ---------------- pop domain ----------------
   logic [1:0]    pop_rst_sync;
   logic          pop_rst_n;
   logic [PW-1:0] rptr_bin, rptr_next, wptr_sync_bin, rd_level_next;
   logic [PW-1:0] wptr_sync [SYNC_STAGES];

   always_ff @(posedge clk_pop or negedge rst_n) begin
      if (!rst_n) pop_rst_sync <= 2'b00;
      else        pop_rst_sync <= {pop_rst_sync[0], 1'b1};
   end
   assign pop_rst_n = pop_rst_sync[1];

   assign re            = pop & ~empty_ff;
   assign rptr_next     = rptr_bin + PW'(re);
   assign rd_level_next = PW'(level_diff(LVL_W_MAX'(wptr_sync_bin), LVL_W_MAX'(rptr_next), PW));

   always_ff @(posedge clk_pop or negedge pop_rst_n) begin
      if (!pop_rst_n) begin
         rptr_bin        <= '0;
         rptr_gray       <= '0;
         rd_level        <= '0;
         empty_ff        <= 1'b1;
         almost_empty_ff <= 1'b1;
      end else begin
         rptr_bin        <= rptr_next;
         rptr_gray       <= rptr_next ^ (rptr_next >> 1);
         rd_level        <= rd_level_next;
         empty_ff        <= (rd_level_next == '0);
         almost_empty_ff <= (rd_level_next <= AE_LVL);
      end
   end

   always_ff @(posedge clk_pop or negedge pop_rst_n) begin
      if (!pop_rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) wptr_sync[i] <= '0;
      end else begin
         wptr_sync[0] <= wptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) wptr_sync[i] <= wptr_sync[i-1];
      end
   end

   dfafn_gray2bin #(.W(PW)) u_wptr_g2b (
      .gray (wptr_sync[SYNC_STAGES-1]),
      .bin  (wptr_sync_bin)
   );

   assign raddr_ff = rptr_bin[AW-1:0];

`ifdef FIFO_DC_WM_ERR_EN
   always_ff @(posedge clk_push or negedge push_rst_n) begin
      if (!push_rst_n)          overflow_ff <= 1'b0;
      else if (push && full_ff) overflow_ff <= 1'b1;
   end

   always_ff @(posedge clk_pop or negedge pop_rst_n) begin
      if (!pop_rst_n)           underflow_ff <= 1'b0;
      else if (pop && empty_ff) underflow_ff <= 1'b1;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_dc_wm_cntl.sv
// tb_fifo_dc_wm_cntl: self-checking bench for fifo_dc_wm_cntl (8 entries, AF 6, AE 2).
`default_nettype none

module tb_fifo_dc_wm_cntl;

   localparam int N = 8;

   logic       clk_push = 1'b0, clk_pop = 1'b0, rst_n = 1'b0, push = 1'b0, pop = 1'b0;
   logic       we, re, full_ff, almost_full_ff, empty_ff, almost_empty_ff;
   logic [2:0] waddr_ff, raddr_ff;
   logic [3:0] wr_level, rd_level;
`ifdef FIFO_DC_WM_ERR_EN
   logic       overflow_ff, underflow_ff;
`endif

   int n_pass = 0, n_chk = 0;
   int wcnt = 0, rcnt = 0;   // accepted pushes / pops since last reset
   bit push_done = 1'b0;

   // 3:7 clock ratio; edges land on multiples of 10, samples never do
   always #30 clk_push = ~clk_push;
   always #70 clk_pop  = ~clk_pop;

   fifo_dc_wm_cntl #(
      .NUM_ENTRIES (8),
      .SYNC_STAGES (2),
      .AF_LEVEL    (6),
      .AE_LEVEL    (2)
   ) dut (
      .clk_pop         (clk_pop),
      .clk_push        (clk_push),
      .rst_n           (rst_n),
      .push            (push),
      .pop             (pop),
      .we              (we),
      .re              (re),
      .waddr_ff        (waddr_ff),
      .raddr_ff        (raddr_ff),
      .full_ff         (full_ff),
      .almost_full_ff  (almost_full_ff),
      .empty_ff        (empty_ff),
      .almost_empty_ff (almost_empty_ff),
      .wr_level        (wr_level),
`ifdef FIFO_DC_WM_ERR_EN
      .rd_level        (rd_level),
      .overflow_ff     (overflow_ff),
      .underflow_ff    (underflow_ff)
`else
      .rd_level        (rd_level)
`endif
   );

   typedef struct {
      string name;
      int    n_push;
      int    n_pop;
      int    full;
      int    af;
      int    empty;
      int    ae;
      int    lvl;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
   endtask

   task automatic do_push(output bit acc);
      @(posedge clk_push); #3;
      push = 1'b1;
      #3;
      acc = we;
      if (acc) chk("push_waddr", int'(waddr_ff), wcnt % N);
      @(posedge clk_push); #3;
      push = 1'b0;
      if (acc) wcnt++;
   endtask

   task automatic do_pop(output bit acc);
      @(posedge clk_pop); #3;
      pop = 1'b1;
      #3;
      acc = re;
      if (acc) chk("pop_raddr", int'(raddr_ff), rcnt % N);
      @(posedge clk_pop); #3;
      pop = 1'b0;
      if (acc) rcnt++;
   endtask

   task automatic settle();
      repeat (8) @(posedge clk_pop);
      #3;
   endtask

   task automatic apply_reset();
      #5;
      rst_n = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      #200;
      chk("rst_full", int'(full_ff), 1);
      chk("rst_af", int'(almost_full_ff), 1);
      chk("rst_empty", int'(empty_ff), 1);
      chk("rst_ae", int'(almost_empty_ff), 1);
      chk("rst_wr_level", int'(wr_level), 0);
      chk("rst_rd_level", int'(rd_level), 0);
      push = 1'b1;
      pop  = 1'b1;
      #1;
      chk("rst_we", int'(we), 0);
      chk("rst_re", int'(re), 0);
`ifdef FIFO_DC_WM_ERR_EN
      chk("rst_overflow", int'(overflow_ff), 0);
      chk("rst_underflow", int'(underflow_ff), 0);
`endif
      push = 1'b0;
      pop  = 1'b0;
      wcnt = 0;
      rcnt = 0;
      #202;
      rst_n = 1'b1;
   endtask

   initial begin
      #20_000_000;
      $display("FAIL global_timeout: simulation still running at t=%0t", $time);
      $fatal(1);
   end

   initial begin
      bit acc;
      bit hit;
      int exp_acc;

      tbl[0] = '{"push3",         3, 0, 0, 0, 0, 0, 3};
      tbl[1] = '{"pop1_to2",      0, 1, 0, 0, 0, 1, 2};
      tbl[2] = '{"push4_to6",     4, 0, 0, 1, 0, 0, 6};
      tbl[3] = '{"push1_to7",     1, 0, 0, 1, 0, 0, 7};
      tbl[4] = '{"push1_full",    1, 0, 1, 1, 0, 0, 8};
      tbl[5] = '{"push2_ignored", 2, 0, 1, 1, 0, 0, 8};
      tbl[6] = '{"pop8_empty",    0, 8, 0, 0, 1, 1, 0};
      tbl[7] = '{"push1_to1",     1, 0, 0, 0, 0, 1, 1};
      tbl[8] = '{"pop1_to0",      0, 1, 0, 0, 1, 1, 0};

      // Reset release: full drops within 3 clk_push edges
      apply_reset();
      hit = 1'b0;
      for (int e = 0; e < 3; e++) begin
         @(posedge clk_push); #3;
         if (!full_ff) begin
            hit = 1'b1;
            break;
         end
      end
      chk("release_full_within3", int'(hit), 1);
      chk("release_af", int'(almost_full_ff), 0);
      settle();
      chk("release_empty", int'(empty_ff), 1);
      chk("release_wr_level", int'(wr_level), 0);
      chk("release_rd_level", int'(rd_level), 0);

      // Fill to full with no pops, then one overflowing push
      for (int k = 1; k <= N; k++) begin
         do_push(acc);
         chk("fill_accept", int'(acc), 1);
         chk($sformatf("fill_af_push%0d", k), int'(almost_full_ff), int'(k >= 6));
         chk($sformatf("fill_full_push%0d", k), int'(full_ff), int'(k == N));
      end
      do_push(acc);
      chk("push9_we", int'(acc), 0);
`ifdef FIFO_DC_WM_ERR_EN
      chk("push9_overflow", int'(overflow_ff), 1);
`endif

      // One pop from full: push side sees it within 4 edges
      do_pop(acc);
      chk("pop_from_full_accept", int'(acc), 1);
      hit = 1'b0;
      for (int e = 0; e < 4; e++) begin
         @(posedge clk_push); #3;
         if (!full_ff) begin
            hit = 1'b1;
            break;
         end
      end
      chk("full_drop_within4", int'(hit), 1);
      chk("wr_level_after_pop", int'(wr_level), 7);
      settle();
      chk("rd_level_after_pop", int'(rd_level), 7);
`ifdef FIFO_DC_WM_ERR_EN
      chk("overflow_sticky", int'(overflow_ff), 1);
`endif

      // Push 3 into empty, drain, then one underflowing pop
      apply_reset();
      settle();
      for (int k = 0; k < 3; k++) do_push(acc);
      hit = 1'b0;
      for (int e = 0; e < 4; e++) begin
         @(posedge clk_pop); #3;
         if (rd_level == 4'd3 && !empty_ff) begin
            hit = 1'b1;
            break;
         end
      end
      chk("rd_level3_within4", int'(hit), 1);
      for (int k = 1; k <= 3; k++) begin
         do_pop(acc);
         chk("drain_accept", int'(acc), 1);
         chk($sformatf("drain_empty_pop%0d", k), int'(empty_ff), int'(k == 3));
      end
      do_pop(acc);
      chk("pop4_re", int'(acc), 0);
`ifdef FIFO_DC_WM_ERR_EN
      chk("pop4_underflow", int'(underflow_ff), 1);
`endif

      // Table-driven settled steps
      apply_reset();
      settle();
      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n_push; k++) begin
            exp_acc = int'((wcnt - rcnt) < N);
            do_push(acc);
            chk($sformatf("%s_push_acc", tbl[i].name), int'(acc), exp_acc);
         end
         for (int k = 0; k < tbl[i].n_pop; k++) begin
            exp_acc = int'((wcnt - rcnt) > 0);
            do_pop(acc);
            chk($sformatf("%s_pop_acc", tbl[i].name), int'(acc), exp_acc);
         end
         settle();
         chk($sformatf("%s_full", tbl[i].name), int'(full_ff), tbl[i].full);
         chk($sformatf("%s_af", tbl[i].name), int'(almost_full_ff), tbl[i].af);
         chk($sformatf("%s_empty", tbl[i].name), int'(empty_ff), tbl[i].empty);
         chk($sformatf("%s_ae", tbl[i].name), int'(almost_empty_ff), tbl[i].ae);
         chk($sformatf("%s_wr_level", tbl[i].name), int'(wr_level), tbl[i].lvl);
         chk($sformatf("%s_rd_level", tbl[i].name), int'(rd_level), tbl[i].lvl);
      end

      // Reset with 5 entries held discards everything
      for (int k = 0; k < 5; k++) do_push(acc);
      settle();
      chk("held5_rd_level", int'(rd_level), 5);
      apply_reset();
      settle();
      chk("midrst_empty", int'(empty_ff), 1);
      chk("midrst_full", int'(full_ff), 0);
      chk("midrst_rd_level", int'(rd_level), 0);
      chk("midrst_wr_level", int'(wr_level), 0);
      do_push(acc);
      chk("midrst_push_acc", int'(acc), 1);
      settle();
      do_pop(acc);
      chk("midrst_pop_acc", int'(acc), 1);
      settle();

      // Random concurrent traffic against an occupancy/address model
      fork
         begin : push_side
            int  cyc;
            int  pct;
            int  occ;
            int  target;
            bit  a;
            cyc    = 0;
            pct    = 90;
            target = wcnt + 40 * 2 * N;
            @(posedge clk_push);
            while (wcnt < target && cyc < 12000) begin
               if (cyc % 64 == 0) pct = (pct == 90) ? 25 : 90;
               #3;
               push = ($urandom_range(99) < pct);
               #3;
               occ = wcnt - rcnt;
               chk("rand_full_not_optimistic", int'(!full_ff && occ == N), 0);
               a = we;
               if (a) begin
                  chk("rand_we_has_room", int'(occ < N), 1);
                  chk("rand_waddr", int'(waddr_ff), wcnt % N);
               end
               @(posedge clk_push);
               if (a) wcnt++;
               cyc++;
            end
            #3;
            push = 1'b0;
            chk("rand_push_budget", int'(wcnt >= target), 1);
            push_done = 1'b1;
         end
         begin : pop_side
            int  cyc;
            int  occ;
            bit  a;
            cyc = 0;
            @(posedge clk_pop);
            while (!(push_done && rcnt == wcnt) && cyc < 20000) begin
               #3;
               pop = ($urandom_range(99) < 75);
               #3;
               occ = wcnt - rcnt;
               chk("rand_empty_not_optimistic", int'(!empty_ff && occ == 0), 0);
               a = re;
               if (a) begin
                  chk("rand_re_has_data", int'(occ > 0), 1);
                  chk("rand_raddr", int'(raddr_ff), rcnt % N);
               end
               @(posedge clk_pop);
               if (a) rcnt++;
               cyc++;
            end
            #3;
            pop = 1'b0;
            chk("rand_drained", int'(rcnt == wcnt), 1);
         end
      join

      settle();
      chk("final_empty", int'(empty_ff), 1);
      chk("final_full", int'(full_ff), 0);
      chk("final_wr_level", int'(wr_level), 0);
      chk("final_rd_level", int'(rd_level), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
